// File: rtl/debug_overlay_ctrl_if.sv
// Overlay controller bus: raster position, live game vectors, updater busy/grant
// handshake and the registered overlay pixel returned to the video mux.
interface debug_overlay_ctrl_if #(
  parameter int F = 16
);
  logic [9:0]   hpos;
  logic [9:0]   vpos;
  logic [F-1:0] playerX;
  logic [F-1:0] playerY;
  logic [F-1:0] facingX;
  logic [F-1:0] facingY;
  logic [F-1:0] vplaneX;
  logic [F-1:0] vplaneY;
  logic         freeze;
  logic         upd_busy;
  logic         upd_gnt;
  logic         snap_stale;
  logic         in_debug_overlay;
  logic [5:0]   debug_rgb;

  modport master (
    output hpos, vpos, playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    output freeze, upd_busy,
    input  upd_gnt, snap_stale, in_debug_overlay, debug_rgb
  );

  modport slave (
    input  hpos, vpos, playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    input  freeze, upd_busy,
    output upd_gnt, snap_stale, in_debug_overlay, debug_rgb
  );
endinterface

// File: rtl/debug_overlay_ctrl.sv
// Debug overlay sequencer: tear-free per-frame snapshot of six game vectors, streamed
// MSB-first one bit per cell into a registered overlay pixel (1-cycle latency).
module debug_overlay_ctrl #(
  parameter int H_VIEW      = 640,
  parameter int DEBUG_SCALE = 3,
  parameter int V_SNAP      = 480,
  parameter int QM          = 6,
  parameter int QN          = 10
) (
  input  logic                clk,
  input  logic                reset,
  debug_overlay_ctrl_if.slave bus
);
  localparam int QMN = QM + QN;
  localparam int HX0 = H_VIEW - (1 << DEBUG_SCALE) * QMN - 1;
  localparam logic [10:0] HX0_W   = 11'(HX0);
  localparam logic [9:0]  HLOAD_W = 10'(HX0 - 1);
  localparam logic [10:0] HDIV_W  = 11'(QM << DEBUG_SCALE);
  localparam logic [9:0]  VEND_W  = 10'(8 << DEBUG_SCALE);
  localparam logic [9:0]  VSNAP_W = 10'(V_SNAP);

  typedef enum logic [1:0] {IDLE, PENDING, CAPTURE} state_t;

  state_t         state_q, state_d;
  logic           stale_q, stale_d;
  logic [QMN-1:0] px_q, py_q, fx_q, fy_q, vx_q, vy_q;
  logic [QMN-1:0] shift_q, shift_d;
  logic           ovl_q, ovl_d;
  logic [1:0]     col_q, col_d;

  logic [10:0] h;  // hpos - HX0, bit 10 acts as the sign
  logic [2:0]  row;
  logic        in_region, gridline, cell_end, line_load, snap_req, frame_start;

  assign h           = {1'b0, bus.hpos} - HX0_W;
  assign row         = bus.vpos[DEBUG_SCALE+2:DEBUG_SCALE];
  assign in_region   = !h[10] && (bus.vpos <= VEND_W);
  assign gridline    = (h[DEBUG_SCALE-1:0] == '0) || (bus.vpos[DEBUG_SCALE-1:0] == '0);
  assign cell_end    = !h[10] && (&h[DEBUG_SCALE-1:0]);
  assign line_load   = (bus.hpos == HLOAD_W);
  assign snap_req    = (bus.hpos == '0) && (bus.vpos == VSNAP_W);
  assign frame_start = (bus.hpos == '0) && (bus.vpos == '0);

  // Freeze outranks the frame-start abandon so a frozen pending capture leaves
  // snap_stale untouched.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      IDLE: begin
        if (snap_req && !bus.freeze) state_d = PENDING;
      end
      PENDING: begin
        if (bus.freeze) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d = IDLE;
          stale_d = 1'b1;
        end else if (!bus.upd_busy) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        stale_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
      fx_q <= '0;
      fy_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
    end else if (state_q == CAPTURE) begin
      px_q <= bus.playerX;
      py_q <= bus.playerY;
      fx_q <= bus.facingX;
      fy_q <= bus.facingY;
      vx_q <= bus.vplaneX;
      vy_q <= bus.vplaneY;
    end
  end

  always_comb begin
    shift_d = shift_q;
    if (line_load) begin
      case (row)
        3'd0:    shift_d = px_q;
        3'd1:    shift_d = py_q;
        3'd3:    shift_d = fx_q;
        3'd4:    shift_d = fy_q;
        3'd6:    shift_d = vx_q;
        3'd7:    shift_d = vy_q;
        default: shift_d = '0;
      endcase
    end else if (cell_end) begin
      shift_d = {shift_q[QMN-2:0], 1'b0};
    end
  end

  always_comb begin
    ovl_d = in_region;
    col_d = 2'b00;
    if (in_region) begin
      if (gridline) begin
        col_d = (h == HDIV_W) ? 2'b10 : 2'b00;
      end else if (row != 3'd2 && row != 3'd5) begin
        col_d = shift_q[QMN-1] ? 2'b11 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      ovl_q   <= 1'b0;
      col_q   <= 2'b00;
    end else begin
      shift_q <= shift_d;
      ovl_q   <= ovl_d;
      col_q   <= col_d;
    end
  end

  assign bus.upd_gnt          = (state_q != CAPTURE);
  assign bus.snap_stale       = stale_q;
  assign bus.in_debug_overlay = ovl_q;
  assign bus.debug_rgb        = {col_q, col_q, col_q};
endmodule

// File: tb/tb_debug_overlay_ctrl.sv
// Bench for debug_overlay_ctrl: compressed raster frames driven directly on hpos/vpos,
// outputs compared against a cell/bit-level reference model of the overlay.
module tb_debug_overlay_ctrl;
  logic clk = 1'b0;
  logic reset;

  debug_overlay_ctrl_if #(.F(16)) bus ();

  debug_overlay_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] vec    [6];  // live vectors pX,pY,fX,fY,vX,vY
  logic [15:0] shadow [6];  // what the overlay should currently be displaying
  logic [15:0] line_vec;
  logic        busy, frz;
  bit          pend, cap, stale_m, stream;
  int          last_h;
  logic [5:0]  exp_rgb;
  logic        exp_ovl, exp_gnt, exp_stale;
  bit          rgb_chk;
  int          rowmap [8] = '{0, 1, -1, 2, 3, -1, 4, 5};

  task automatic model_reset();
    pend = 0; cap = 0; stale_m = 0; stream = 0;
    last_h = -10; line_vec = 16'h0;
    foreach (shadow[i]) shadow[i] = 16'h0;
  endtask

  task automatic new_vectors();
    foreach (vec[i]) vec[i] = 16'($urandom);
  endtask

  // Drive one pixel clock, advance the model, return just after the edge.
  task automatic cyc(input int h, input int v);
    int hh, k, r;
    logic [1:0] c;
    bit inreg;
    bus.hpos = 10'(h); bus.vpos = 10'(v);
    bus.playerX = vec[0]; bus.playerY = vec[1];
    bus.facingX = vec[2]; bus.facingY = vec[3];
    bus.vplaneX = vec[4]; bus.vplaneY = vec[5];
    bus.upd_busy = busy; bus.freeze = frz;
    hh = h - 511;
    stream = (h == last_h + 1) && (last_h == 510 || stream);
    inreg = (hh >= 0) && (v <= 64);
    r = (v / 8) % 8;
    rgb_chk = 1; c = 2'b00;
    if (inreg) begin
      if (hh % 8 == 0 || v % 8 == 0) begin
        c = (hh == 48) ? 2'b10 : 2'b00;
      end else if (rowmap[r] >= 0) begin
        k = hh / 8;
        rgb_chk = stream;
        if (k < 16) c = line_vec[15-k] ? 2'b11 : 2'b01;
        else c = 2'b01;
      end
    end
    exp_rgb = {c, c, c};
    exp_ovl = inreg;
    if (h == 510) begin
      if (rowmap[r] >= 0) line_vec = shadow[rowmap[r]];
      else line_vec = 16'h0;
    end
    if (cap) begin
      foreach (shadow[i]) shadow[i] = vec[i];
      cap = 0; stale_m = 0;
    end else if (pend) begin
      if (frz) pend = 0;
      else if (h == 0 && v == 0) begin pend = 0; stale_m = 1; end
      else if (!busy) begin pend = 0; cap = 1; end
    end else if (h == 0 && v == 480 && !frz) begin
      pend = 1;
    end
    exp_gnt = !cap;
    exp_stale = stale_m;
    last_h = h;
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int bf, input int bt);
    for (int v = 470; v <= 492; v++)
      for (int h = 0; h < 4; h++) begin
        busy = (v >= bf && v < bt);
        cyc(h, v);
      end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_debug_overlay !== 1'b0 || bus.debug_rgb !== 6'h00) begin
      errors++;
      $display("FAIL reset_pixel got ovl=%b rgb=%h want ovl=0 rgb=00", bus.in_debug_overlay, bus.debug_rgb);
    end
    checks++;
    if (bus.upd_gnt !== 1'b1 || bus.snap_stale !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got gnt=%b stale=%b want gnt=1 stale=0", bus.upd_gnt, bus.snap_stale);
    end
    reset = 1'b0;
    new_vectors();
    // no capture yet: every vector row must render zero bits
    for (int v = 0; v <= 64; v += 3) begin
      cyc(0, v);
      for (int h = 508; h <= 645; h++) begin
        cyc(h, v);
        if (rgb_chk) begin
          checks++;
          if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
            errors++;
            $display("FAIL reset_shadow v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
          end
        end
      end
    end
  endtask

  task automatic test_capture();
    logic want_g;
    logic [5:0] want;
    new_vectors();
    vec[0] = 16'h8001;
    busy = 1'b0;
    for (int v = 470; v <= 492; v++)
      for (int h = 0; h < 4; h++) begin
        cyc(h, v);
        want_g = !(v == 480 && h == 1);
        checks++;
        if (bus.upd_gnt !== want_g || bus.snap_stale !== 1'b0) begin
          errors++;
          $display("FAIL capture_gnt v=%0d h=%0d got gnt=%b stale=%b want gnt=%b stale=0", v, h, bus.upd_gnt, bus.snap_stale, want_g);
        end
      end
    for (int v = 0; v <= 64; v += 3) begin
      cyc(0, v);
      for (int h = 508; h <= 645; h++) begin
        cyc(h, v);
        if (rgb_chk) begin
          checks++;
          if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
            errors++;
            $display("FAIL capture_px v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
          end
        end
      end
    end
    cyc(0, 3);
    for (int h = 508; h <= 640; h++) begin
      cyc(h, 3);
      if (h >= 512 && h <= 638 && ((h - 511) % 8) != 0) begin
        want = (h <= 518 || h >= 632) ? 6'h3F : 6'h15;
        checks++;
        if (bus.debug_rgb !== want) begin
          errors++;
          $display("FAIL px8001 h=%0d got rgb=%h want rgb=%h", h, bus.debug_rgb, want);
        end
      end
    end
  endtask

  task automatic test_busy_hold();
    logic want_g;
    new_vectors();
    for (int v = 470; v <= 492; v++)
      for (int h = 0; h < 4; h++) begin
        busy = (v < 490);
        cyc(h, v);
        want_g = !(v == 490 && h == 0);
        checks++;
        if (bus.upd_gnt !== want_g) begin
          errors++;
          $display("FAIL busy_gnt v=%0d h=%0d got gnt=%b want gnt=%b", v, h, bus.upd_gnt, want_g);
        end
      end
    for (int v = 0; v <= 64; v += 3) begin
      cyc(0, v);
      for (int h = 508; h <= 645; h++) begin
        cyc(h, v);
        if (rgb_chk) begin
          checks++;
          if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
            errors++;
            $display("FAIL busy_px v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
          end
        end
      end
    end
  endtask

  task automatic test_abandon();
    new_vectors();
    blank(470, 1000);
    cyc(0, 0);
    checks++;
    if (bus.snap_stale !== 1'b1) begin
      errors++;
      $display("FAIL abandon_stale got stale=%b want stale=1", bus.snap_stale);
    end
    for (int v = 0; v <= 64; v += 3) begin
      cyc(0, v);
      for (int h = 508; h <= 645; h++) begin
        cyc(h, v);
        if (rgb_chk) begin
          checks++;
          if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
            errors++;
            $display("FAIL abandon_px v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
          end
        end
      end
    end
    busy = 1'b0;
    blank(0, 0);
    checks++;
    if (bus.snap_stale !== 1'b0) begin
      errors++;
      $display("FAIL abandon_clear got stale=%b want stale=0", bus.snap_stale);
    end
  endtask

  task automatic test_freeze();
    frz = 1'b1;
    new_vectors();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        // freeze rising while a capture is pending drops it without a capture
        frz = 1'b0; busy = 1'b1;
        cyc(0, 480);
        frz = 1'b1;
        cyc(1, 480);
        frz = 1'b0; busy = 1'b0;
        for (int h = 2; h < 6; h++) begin
          cyc(h, 480);
          checks++;
          if (bus.upd_gnt !== 1'b1 || bus.snap_stale !== 1'b0) begin
            errors++;
            $display("FAIL freeze_pending h=%0d got gnt=%b stale=%b want gnt=1 stale=0", h, bus.upd_gnt, bus.snap_stale);
          end
        end
      end
      blank(0, 0);
      for (int v = 0; v <= 64; v += 3) begin
        cyc(0, v);
        for (int h = 508; h <= 645; h++) begin
          cyc(h, v);
          if (rgb_chk) begin
            checks++;
            if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
              errors++;
              $display("FAIL freeze_px f=%0d v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", f, v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
            end
          end
        end
      end
    end
  endtask

  task automatic test_geometry();
    int hs [6] = '{559, 530, 510, 511, 520, 520};
    int vs [6] = '{10, 20, 5, 30, 64, 65};
    logic [5:0] wr [6] = '{6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic wo [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cyc(hs[i], vs[i]);
      checks++;
      if (bus.debug_rgb !== wr[i] || bus.in_debug_overlay !== wo[i]) begin
        errors++;
        $display("FAIL geometry h=%0d v=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", hs[i], vs[i], bus.debug_rgb, bus.in_debug_overlay, wr[i], wo[i]);
      end
    end
  endtask

  task automatic test_random();
    int bf, bt;
    for (int f = 0; f < 3; f++) begin
      new_vectors();
      frz = ($urandom_range(0, 3) == 0);
      bf = $urandom_range(470, 486);
      bt = ($urandom_range(0, 3) == 0) ? 1000 : bf + $urandom_range(0, 12);
      for (int v = 470; v <= 492; v++)
        for (int h = 0; h < 4; h++) begin
          busy = (v >= bf && v < bt);
          cyc(h, v);
          checks++;
          if (bus.upd_gnt !== exp_gnt || bus.snap_stale !== exp_stale) begin
            errors++;
            $display("FAIL random_hs f=%0d v=%0d h=%0d got gnt=%b stale=%b want gnt=%b stale=%b", f, v, h, bus.upd_gnt, bus.snap_stale, exp_gnt, exp_stale);
          end
        end
      for (int v = 0; v <= 64; v += 3) begin
        cyc(0, v);
        for (int h = 508; h <= 645; h++) begin
          cyc(h, v);
          if (rgb_chk) begin
            checks++;
            if (bus.debug_rgb !== exp_rgb || bus.in_debug_overlay !== exp_ovl) begin
              errors++;
              $display("FAIL random_px f=%0d v=%0d h=%0d got rgb=%h ovl=%b want rgb=%h ovl=%b", f, v, h, bus.debug_rgb, bus.in_debug_overlay, exp_rgb, exp_ovl);
            end
          end
        end
      end
      checks++;
      if (bus.snap_stale !== exp_stale) begin
        errors++;
        $display("FAIL random_stale f=%0d got stale=%b want stale=%b", f, bus.snap_stale, exp_stale);
      end
    end
    frz = 1'b0;
    busy = 1'b0;
  endtask

  task automatic test_async_reset();
    cyc(0, 3);
    for (int h = 508; h <= 514; h++) cyc(h, 3);
    checks++;
    if (bus.in_debug_overlay !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got ovl=%b want ovl=1", bus.in_debug_overlay);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.in_debug_overlay !== 1'b0 || bus.debug_rgb !== 6'h00 || bus.upd_gnt !== 1'b1 || bus.snap_stale !== 1'b0) begin
      errors++;
      $display("FAIL areset got ovl=%b rgb=%h gnt=%b stale=%b want ovl=0 rgb=00 gnt=1 stale=0", bus.in_debug_overlay, bus.debug_rgb, bus.upd_gnt, bus.snap_stale);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    busy = 1'b0;
    frz = 1'b0;
    foreach (vec[i]) vec[i] = 16'h0;
    model_reset();
    bus.hpos = '0; bus.vpos = '0;
    bus.playerX = '0; bus.playerY = '0; bus.facingX = '0;
    bus.facingY = '0; bus.vplaneX = '0; bus.vplaneY = '0;
    bus.upd_busy = 1'b0; bus.freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_capture();
    test_busy_hold();
    test_abandon();
    test_freeze();
    test_geometry();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
